// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stability counter, accepted level,
// edge strobes and a once-per-press long-press strobe.
module debounce_channel #(
    parameter int BITS        = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit INIT_LEVEL  = 1'b0,
    parameter int HOLD_BITS   = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic hold_o
);

    localparam logic [BITS:0]        CNT_ONE  = {{BITS{1'b0}}, 1'b1};
    localparam logic [HOLD_BITS-1:0] HOLD_ONE = {{(HOLD_BITS-1){1'b0}}, 1'b1};
    localparam logic [HOLD_BITS-1:0] HOLD_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   cand_q, cand_d;
    logic [BITS:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   hold_q, hold_d;
    logic [HOLD_BITS-1:0]   hold_cnt_q, hold_cnt_d;
    logic                   hold_done_q, hold_done_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], in_i};
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        hold_d      = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        hold_done_d = hold_done_q;

        // Any disagreement with the candidate restarts the stability count.
        if (s != cand_q) begin
            cand_d = s;
            cnt_d  = '0;
        end else if (!cnt_q[BITS]) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (level_q != cand_q) begin
            level_d = cand_q;
            rise_d  = cand_q;
            fall_d  = !cand_q;
        end

        // Hold only counts while the level is 1 now and stays 1 this edge,
        // so it can never coincide with a rise or fall strobe.
        if (!(level_q && level_d)) begin
            hold_cnt_d  = '0;
            hold_done_d = 1'b0;
        end else if (!hold_done_q) begin
            if (hold_cnt_q == HOLD_MAX) begin
                hold_d      = 1'b1;
                hold_done_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= {SYNC_STAGES{INIT_LEVEL}};
            cand_q      <= INIT_LEVEL;
            cnt_q       <= '0;
            level_q     <= INIT_LEVEL;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            hold_q      <= 1'b0;
            hold_cnt_q  <= '0;
            hold_done_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            hold_q      <= hold_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_done_q <= hold_done_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign hold_o  = hold_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced inputs sharing one clock and reset.
module debounce_bank #(
    parameter int CHANNELS    = 4,
    parameter int BITS        = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit INIT_LEVEL  = 1'b0,
    parameter int HOLD_BITS   = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .BITS        (BITS),
            .SYNC_STAGES (SYNC_STAGES),
            .INIT_LEVEL  (INIT_LEVEL),
            .HOLD_BITS   (HOLD_BITS)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_i    (in[g]),
            .level_o (level[g]),
            .rise_o  (rise[g]),
            .fall_o  (fall[g]),
            .hold_o  (hold[g])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios followed by random bouncing,
// all compared every cycle against a sliding-window reference model.
module tb_debounce_bank;

    localparam int CH   = 4;
    localparam int B    = 3;
    localparam int SYNC = 2;
    localparam int HB   = 5;
    localparam int WIN  = (2 ** B) + 2;
    localparam int QL   = SYNC + WIN;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] in_r;
    logic [CH-1:0] level, rise, fall, hold;
    logic [CH-1:0] in1;
    logic [CH-1:0] level1, rise1, fall1, hold1;

    int checks = 0;
    int errors = 0;

    logic [CH-1:0] hist[$];
    logic [CH-1:0] lvl_m, rise_m, fall_m, hold_m;
    int            age[CH];
    int            rise_n[CH], fall_n[CH], hold_n[CH];
    bit            check_init1;

    always #5 clk = ~clk;

    debounce_bank #(.CHANNELS(CH), .BITS(B), .SYNC_STAGES(SYNC), .INIT_LEVEL(1'b0), .HOLD_BITS(HB)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_r), .level(level), .rise(rise), .fall(fall), .hold(hold)
    );

    debounce_bank #(.CHANNELS(CH), .BITS(B), .SYNC_STAGES(SYNC), .INIT_LEVEL(1'b1), .HOLD_BITS(HB)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .level(level1), .rise(rise1), .fall(fall1), .hold(hold1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < QL; i++) hist.push_back('0);
        lvl_m  = '0;
        rise_m = '0;
        fall_m = '0;
        hold_m = '0;
        for (int c = 0; c < CH; c++) age[c] = -1;
    endtask

    // The level follows a value once the synchronised input has shown that
    // value on WIN consecutive edges; hold fires 2^HB edges after the rise.
    task automatic model_edge();
        logic [CH-1:0] w;
        logic          v;
        bit            stable;
        hist.push_back(in_r);
        void'(hist.pop_front());
        rise_m = '0;
        fall_m = '0;
        hold_m = '0;
        for (int c = 0; c < CH; c++) begin
            w      = hist[0];
            v      = w[c];
            stable = 1'b1;
            for (int i = 0; i < WIN; i++) begin
                w = hist[i];
                if (w[c] != v) stable = 1'b0;
            end
            if (stable && (v != lvl_m[c])) begin
                lvl_m[c] = v;
                rise_m[c] = v;
                fall_m[c] = !v;
                age[c] = v ? 0 : -1;
            end else if (lvl_m[c] && age[c] >= 0) begin
                age[c]++;
                if (age[c] == 2 ** HB) begin
                    hold_m[c] = 1'b1;
                    age[c] = -1;
                end
            end
            if (!lvl_m[c]) age[c] = -1;
        end
    endtask

    task automatic compare_all();
        chk("level", 32'(level), 32'(lvl_m));
        chk("rise",  32'(rise),  32'(rise_m));
        chk("fall",  32'(fall),  32'(fall_m));
        chk("hold",  32'(hold),  32'(hold_m));
        for (int c = 0; c < CH; c++) begin
            rise_n[c] += int'(rise[c]);
            fall_n[c] += int'(fall[c]);
            hold_n[c] += int'(hold[c]);
        end
        if (check_init1) begin
            chk("init1_level", 32'(level1), 32'hF);
            chk("init1_strobes", 32'({rise1, fall1, hold1}), 32'h0);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) begin
            rise_n[c] = 0;
            fall_n[c] = 0;
            hold_n[c] = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_r  = '0;
        in1   = '1;
        check_init1 = 1'b0;
        clear_counts();
        model_reset();

        // Reset state
        #12;
        chk("reset_level", 32'(level), 32'h0);
        chk("reset_strobes", 32'({rise, fall, hold}), 32'h0);
        chk("reset_init1_level", 32'(level1), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        check_init1 = 1'b1;
        step(20);
        check_init1 = 1'b0;

        // Basic press and long press on ch0
        clear_counts();
        in_r[0] = 1'b1;
        step(11);
        chk("press_level_before", 32'(level[0]), 32'h0);
        step(1);
        chk("press_level_12", 32'(level[0]), 32'h1);
        chk("press_rise_12", 32'(rise[0]), 32'h1);
        step(1);
        chk("press_rise_one_cycle", 32'(rise[0]), 32'h0);
        step(30);
        chk("hold_not_yet", 32'(hold_n[0]), 32'h0);
        step(1);
        chk("hold_at_32", 32'(hold[0]), 32'h1);
        step(100);
        chk("hold_once", 32'(hold_n[0]), 32'h1);
        chk("press_rise_count", 32'(rise_n[0]), 32'h1);

        in_r[0] = 1'b0;
        step(12);
        chk("release_fall_12", 32'(fall[0]), 32'h1);
        step(8);
        in_r[0] = 1'b1;
        step(12 + 32 + 5);
        chk("repeat_hold", 32'(hold_n[0]), 32'h2);
        in_r[0] = 1'b0;
        step(20);

        // Bounce on ch0
        clear_counts();
        in_r[0] = 1'b1; step(3);
        in_r[0] = 1'b0; step(3);
        in_r[0] = 1'b1; step(11);
        chk("bounce_no_strobe", 32'(rise_n[0] + fall_n[0]), 32'h0);
        step(1);
        chk("bounce_rise_12", 32'(rise[0]), 32'h1);
        step(5);
        chk("bounce_one_rise", 32'(rise_n[0]), 32'h1);

        // Short glitch on ch1
        in_r[1] = 1'b1; step(8);
        in_r[1] = 1'b0; step(20);
        chk("glitch_strobes", 32'(rise_n[1] + fall_n[1]), 32'h0);
        chk("glitch_level", 32'(level[1]), 32'h0);

        // ch0 rises while ch3 falls in the same cycle
        in_r[3] = 1'b1; in_r[0] = 1'b0; step(15);
        clear_counts();
        in_r[0] = 1'b1; in_r[3] = 1'b0; step(12);
        chk("multi_rise0", 32'(rise[0]), 32'h1);
        chk("multi_fall3", 32'(fall[3]), 32'h1);
        chk("multi_others", 32'({rise[2:1], fall[2:1]}), 32'h0);
        step(5);

        // Asynchronous reset in the middle of a count on ch2
        in_r[2] = 1'b1;
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_level", 32'(level), 32'h0);
        chk("async_strobes", 32'({rise, fall, hold}), 32'h0);
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(11);
        chk("rst_restart_before", 32'(level[2]), 32'h0);
        step(1);
        chk("rst_restart_rise", 32'(rise[2]), 32'h1);

        // Random bouncing on all channels
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 11) == 0) in_r[c] = ~in_r[c];
            end
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
